// File: rtl/peak_det_pkg.sv
// ---------------------------------------------------------------------------
// peak_det_pkg
// Shared definitions for the ADC peak detector: the controller state
// encoding and the default values of the block parameters.
// No ports (package).
// ---------------------------------------------------------------------------
package peak_det_pkg;

   // Default parameter values used by adc_peak_detector
   localparam int DEF_WIDTH     = 12;
   localparam int DEF_FLAG_LEN  = 4;
   localparam int DEF_DEAD_LEN  = 16;
   localparam int DEF_MAX_TRACK = 64;

   // Width of the shared down-counter
   localparam int TIMER_WIDTH = 8;

   // Controller states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      TRACK = 3'd2,
      FLAG  = 3'd3,
      DEAD  = 3'd4
   } state_t;

endpackage

// File: rtl/peak_det_timer.sv
// ---------------------------------------------------------------------------
// peak_det_timer
// Loadable 8-bit down-counter with a zero flag. The peak detector reuses
// one instance to count tracked samples, flag cycles and dead-time cycles,
// since only one of those is ever active at a time.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-high reset (count -> 0)
//   i_load       in   load i_loadValue (has priority over i_dec)
//   i_loadValue  in   8-bit value to load
//   i_dec        in   decrement by one, holding at zero
//   o_zero       out  count is zero
// ---------------------------------------------------------------------------
module peak_det_timer
   import peak_det_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_load,
   input  logic [TIMER_WIDTH-1:0] i_loadValue,
   input  logic                   i_dec,
   output logic                   o_zero
);

   logic [TIMER_WIDTH-1:0] r_count;

   // Load wins over decrement; decrementing stops at zero so a stray
   // decrement request can never wrap the counter around.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/adc_peak_detector.sv
// ---------------------------------------------------------------------------
// adc_peak_detector
// Waits for an ADC sample above threshold, tracks the maximum of the pulse
// until it falls back to/below threshold (or MAX_TRACK samples have been
// seen), publishes the maximum on peak_value with a FLAG_LEN-cycle
// peak_flag, then ignores input for DEAD_LEN cycles.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-high reset
//   adc_data     in   [WIDTH] ADC sample (unsigned)
//   adc_valid    in   sample strobe
//   threshold    in   [WIDTH] trigger level (strictly-greater triggers)
//   enable       in   arm; dropping it in WAIT/TRACK aborts the event
//   peak_value   out  [WIDTH] last published peak
//   peak_flag    out  high FLAG_LEN cycles after each accepted event
//   busy         out  high in TRACK, FLAG and DEAD
//   event_count  out  [16] accepted events, saturating
//
// Build option: define PEAK_DET_EVENT_COUNT_EN to include the event
// counter; otherwise event_count is tied to zero.
// ---------------------------------------------------------------------------
module adc_peak_detector
   import peak_det_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int FLAG_LEN  = DEF_FLAG_LEN,
   parameter int DEAD_LEN  = DEF_DEAD_LEN,
   parameter int MAX_TRACK = DEF_MAX_TRACK
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] adc_data,
   input  logic             adc_valid,
   input  logic [WIDTH-1:0] threshold,
   input  logic             enable,
   output logic [WIDTH-1:0] peak_value,
   output logic             peak_flag,
   output logic             busy,
   output logic [15:0]      event_count
);

   // Timer reload values. The timer counts the cycles/samples still to go
   // after the current one, hence the -1 (flag, dead) and -2 (track: the
   // triggering sample already counts as the first).
   localparam logic [TIMER_WIDTH-1:0] FLAG_LOAD  = TIMER_WIDTH'(FLAG_LEN - 1);
   localparam logic [TIMER_WIDTH-1:0] DEAD_LOAD  =
      TIMER_WIDTH'((DEAD_LEN == 0) ? 0 : DEAD_LEN - 1);
   localparam logic [TIMER_WIDTH-1:0] TRACK_LOAD =
      TIMER_WIDTH'((MAX_TRACK >= 2) ? MAX_TRACK - 2 : 0);

   state_t                 r_state;
   logic [WIDTH-1:0]       r_peakReg;
   logic [WIDTH-1:0]       r_peakValue;
   logic                   r_peakFlag;
   logic                   r_busy;

   logic                   w_trigger;
   logic                   w_trackEnd;
   logic                   w_flagEntry;
   logic [WIDTH-1:0]       w_newMax;
   logic                   w_timerZero;
   logic                   w_timerLoad;
   logic                   w_timerDec;
   logic [TIMER_WIDTH-1:0] w_timerLoadValue;

   // Decisions shared by the state register and the timer control.
   // w_trackEnd is only meaningful with adc_valid in TRACK: the sample is
   // at/below threshold, or it is the MAX_TRACK-th sample of the event.
   always_comb begin
      w_trigger   = adc_valid && (adc_data > threshold);
      w_newMax    = (adc_data > r_peakReg) ? adc_data : r_peakReg;
      w_trackEnd  = (adc_data <= threshold) || w_timerZero;
      w_flagEntry = 1'b0;
      if (enable) begin
         if ((r_state == WAIT) && w_trigger && (MAX_TRACK == 1)) begin
            w_flagEntry = 1'b1;
         end else if ((r_state == TRACK) && adc_valid && w_trackEnd) begin
            w_flagEntry = 1'b1;
         end
      end
   end

   // Timer control: reload on every phase entry, decrement while a phase
   // runs. In TRACK only valid samples advance the count.
   always_comb begin
      w_timerLoad      = 1'b0;
      w_timerDec       = 1'b0;
      w_timerLoadValue = '0;
      if (w_flagEntry) begin
         w_timerLoad      = 1'b1;
         w_timerLoadValue = FLAG_LOAD;
      end else begin
         case (r_state)
            WAIT: begin
               if (enable && w_trigger) begin
                  w_timerLoad      = 1'b1;
                  w_timerLoadValue = TRACK_LOAD;
               end
            end
            TRACK: begin
               if (enable && adc_valid) begin
                  w_timerDec = 1'b1;
               end
            end
            FLAG: begin
               if (w_timerZero) begin
                  w_timerLoad      = (DEAD_LEN != 0);
                  w_timerLoadValue = DEAD_LOAD;
               end else begin
                  w_timerDec = 1'b1;
               end
            end
            DEAD: begin
               w_timerDec = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   peak_det_timer uTimer (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_timerLoad),
      .i_loadValue (w_timerLoadValue),
      .i_dec       (w_timerDec),
      .o_zero      (w_timerZero)
   );

   // Main controller. peak_value is only written on entry to FLAG, so it
   // stays put through the flag window and across aborted events. busy and
   // peak_flag are registered alongside the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_peakReg   <= '0;
         r_peakValue <= '0;
         r_peakFlag  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (!enable) begin
                  r_state <= IDLE;
               end else if (w_trigger) begin
                  r_peakReg <= adc_data;
                  r_busy    <= 1'b1;
                  if (w_flagEntry) begin
                     r_peakValue <= adc_data;
                     r_peakFlag  <= 1'b1;
                     r_state     <= FLAG;
                  end else begin
                     r_state <= TRACK;
                  end
               end
            end
            TRACK: begin
               if (!enable) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (adc_valid) begin
                  r_peakReg <= w_newMax;
                  if (w_flagEntry) begin
                     r_peakValue <= w_newMax;
                     r_peakFlag  <= 1'b1;
                     r_state     <= FLAG;
                  end
               end
            end
            FLAG: begin
               if (w_timerZero) begin
                  r_peakFlag <= 1'b0;
                  if (DEAD_LEN != 0) begin
                     r_state <= DEAD;
                  end else begin
                     r_state <= enable ? WAIT : IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            DEAD: begin
               if (w_timerZero) begin
                  r_state <= enable ? WAIT : IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_peakFlag <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign peak_value = r_peakValue;
   assign peak_flag  = r_peakFlag;
   assign busy       = r_busy;

`ifdef PEAK_DET_EVENT_COUNT_EN
   logic [15:0] r_eventCount;

   // Counts accepted events (FLAG entries), sticking at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_eventCount <= '0;
      end else if (w_flagEntry && (r_eventCount != 16'hFFFF)) begin
         r_eventCount <= r_eventCount + 16'd1;
      end
   end

   assign event_count = r_eventCount;
`else
   assign event_count = 16'd0;
`endif

endmodule

// File: tb/tb_adc_peak_detector.sv
// ---------------------------------------------------------------------------
// tb_adc_peak_detector
// Directed bench for adc_peak_detector with default parameters
// (WIDTH 12, FLAG_LEN 4, DEAD_LEN 16, MAX_TRACK 64). Expected event_count
// follows the PEAK_DET_EVENT_COUNT_EN build option.
// ---------------------------------------------------------------------------
module tb_adc_peak_detector;

`ifdef PEAK_DET_EVENT_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] adc_data;
   logic        adc_valid;
   logic [11:0] threshold;
   logic        enable;
   logic [11:0] peak_value;
   logic        peak_flag;
   logic        busy;
   logic [15:0] event_count;

   int total = 0;
   int bad   = 0;
   int expEvents = 0;

   adc_peak_detector dut (
      .clk         (clk),
      .reset       (reset),
      .adc_data    (adc_data),
      .adc_valid   (adc_valid),
      .threshold   (threshold),
      .enable      (enable),
      .peak_value  (peak_value),
      .peak_flag   (peak_flag),
      .busy        (busy),
      .event_count (event_count)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   // Present one cycle of input, let the edge happen, sample 1 unit later
   task automatic applyStimulus(input logic valid, input logic [11:0] data);
      adc_valid = valid;
      adc_data  = data;
      @(posedge clk);
      #1;
   endtask

   task automatic stepCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 12'd0);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Records an accepted event in the expected event counter
   task automatic noteEvent();
      if (COUNT_EN) expEvents++;
   endtask

   // Directed scenario sequence
   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      adc_valid = 1'b0;
      adc_data  = '0;
      threshold = 12'd100;
      @(posedge clk);
      #1;
      checkOutput("rst_value", peak_value, 0);
      checkOutput("rst_flag", peak_flag, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_count", event_count, 0);
      reset  = 1'b0;
      enable = 1'b1;
      stepCycles(1);

      // Basic pulse 50,120,300,250,80
      applyStimulus(1'b1, 12'd50);
      checkOutput("s1_nobusy", busy, 0);
      applyStimulus(1'b1, 12'd120);
      checkOutput("s1_busy", busy, 1);
      applyStimulus(1'b1, 12'd300);
      applyStimulus(1'b1, 12'd250);
      checkOutput("s1_preflag", peak_flag, 0);
      applyStimulus(1'b1, 12'd80);
      noteEvent();
      checkOutput("s1_flag", peak_flag, 1);
      checkOutput("s1_value", peak_value, 300);
      checkOutput("s1_count", event_count, expEvents);
      for (int i = 0; i < 3; i++) begin
         stepCycles(1);
         checkOutput("s1_flag_hold", peak_flag, 1);
         checkOutput("s1_value_hold", peak_value, 300);
      end
      stepCycles(1);
      checkOutput("s1_flag_end", peak_flag, 0);
      checkOutput("s1_dead_busy", busy, 1);

      // Larger pulse during dead time is ignored
      applyStimulus(1'b1, 12'd150);
      applyStimulus(1'b1, 12'd500);
      applyStimulus(1'b1, 12'd400);
      applyStimulus(1'b1, 12'd50);
      stepCycles(11);
      checkOutput("dead_busy", busy, 1);
      checkOutput("dead_value", peak_value, 300);
      checkOutput("dead_flag", peak_flag, 0);
      stepCycles(1);
      checkOutput("dead_over", busy, 0);
      checkOutput("dead_count", event_count, expEvents);

      // Sample equal to threshold does not trigger
      applyStimulus(1'b1, 12'd100);
      checkOutput("eq_busy", busy, 0);
      checkOutput("eq_flag", peak_flag, 0);
      applyStimulus(1'b1, 12'd100);
      checkOutput("eq_busy2", busy, 0);

      // 70 samples of 200: flag on the 64th
      for (int i = 1; i <= 70; i++) begin
         applyStimulus(1'b1, 12'd200);
         if (i == 1) checkOutput("max_busy", busy, 1);
         if (i == 63) checkOutput("max_noflag63", peak_flag, 0);
         if (i == 64) begin
            noteEvent();
            checkOutput("max_flag64", peak_flag, 1);
            checkOutput("max_value", peak_value, 200);
            checkOutput("max_count", event_count, expEvents);
         end
      end
      stepCycles(13);
      checkOutput("max_dead_busy", busy, 1);
      stepCycles(1);
      checkOutput("max_dead_over", busy, 0);
      applyStimulus(1'b1, 12'd200);
      checkOutput("max_retrig", busy, 1);
      applyStimulus(1'b1, 12'd10);
      noteEvent();
      checkOutput("max2_flag", peak_flag, 1);
      checkOutput("max2_value", peak_value, 200);
      checkOutput("max2_count", event_count, expEvents);
      stepCycles(20);
      checkOutput("max2_idle", busy, 0);

      // Enable dropped mid-TRACK
      applyStimulus(1'b1, 12'd150);
      checkOutput("abort_busy", busy, 1);
      applyStimulus(1'b1, 12'd400);
      enable = 1'b0;
      applyStimulus(1'b1, 12'd600);
      checkOutput("abort_nobusy", busy, 0);
      checkOutput("abort_flag", peak_flag, 0);
      checkOutput("abort_value", peak_value, 200);
      checkOutput("abort_count", event_count, expEvents);
      stepCycles(1);
      checkOutput("abort_flag2", peak_flag, 0);
      enable = 1'b1;
      stepCycles(1);

      // Reset in the second flag cycle
      applyStimulus(1'b1, 12'd250);
      applyStimulus(1'b1, 12'd90);
      noteEvent();
      checkOutput("r_flag1", peak_flag, 1);
      checkOutput("r_value", peak_value, 250);
      stepCycles(1);
      checkOutput("r_flag2", peak_flag, 1);
      #2;
      reset = 1'b1;
      #1;
      expEvents = 0;
      checkOutput("r_async_flag", peak_flag, 0);
      checkOutput("r_async_value", peak_value, 0);
      checkOutput("r_async_count", event_count, 0);
      checkOutput("r_async_busy", busy, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      stepCycles(1);

      // Fresh event with a raised threshold
      threshold = 12'd150;
      applyStimulus(1'b1, 12'd130);
      checkOutput("thr_nobusy", busy, 0);
      applyStimulus(1'b1, 12'd170);
      checkOutput("thr_busy", busy, 1);
      applyStimulus(1'b1, 12'd140);
      noteEvent();
      checkOutput("thr_flag", peak_flag, 1);
      checkOutput("thr_value", peak_value, 170);
      checkOutput("thr_count", event_count, expEvents);
      stepCycles(3);
      checkOutput("thr_flag_hold", peak_flag, 1);
      stepCycles(1);
      checkOutput("thr_flag_end", peak_flag, 0);
      checkOutput("thr_dead", busy, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
